burst_mem_responder: RTL
========================

Name: burst_mem_responder

Overview:
- Memory-side responder for the 64-bit, 4-beat burst protocol driven by cacheline_adapter (pmem_* interface).
- Stores 256-bit lines in internal arrays. Serves read and write bursts after a programmable latency.
- Acts as the synthesizable physical-memory endpoint for mp4 integration and for adapter-level benches.

Parameters:
- LINE_IDX_W, 8, line-index bits; storage holds 2**LINE_IDX_W lines of 256 bits.
- LATENCY, 6, cycles from request acceptance to the first beat; legal range 1..255.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- pmem_read  input  1  read request; held by the master until the last beat
- pmem_write  input  1  write request; held by the master until the last beat
- pmem_address  input  32  line address; bits [4:0] ignored
- pmem_wdata  input  64  write beat currently presented by the master
- pmem_resp  output  1  beat strobe; high for exactly 4 consecutive cycles per burst
- pmem_rdata  output  64  read beat, valid while pmem_resp is high
- proto_err  output  1  sticky protocol-violation flag (see Optional Feature)

Behaviour:
- Reset (async, rst=1): state IDLE; pmem_resp=0, pmem_rdata=0, proto_err=0; latency counter and beat counter = 0. Storage contents are not reset.
- Line index = pmem_address[5+LINE_IDX_W-1:5]. Higher address bits alias (wrap modulo storage size). Beat k maps to line bits [64k+63:64k].
- States:
  - IDLE: if pmem_read or pmem_write is high, latch index and op, load counter = LATENCY-1, go to WAIT. If both are high, op = READ.
  - WAIT: decrement the counter each cycle. On 0, go to BURST with beat = 0. If the request drops (both read and write low), abort to IDLE with no storage change.
  - BURST: pmem_resp=1 every cycle. Beat increments 0..3; after beat 3, go to DONE. Once entered, the burst completes even if the request drops.
  - DONE: one cycle with pmem_resp=0 so the master can deassert; then IDLE. A request still high in DONE is not accepted until IDLE.
- Timing: cycle 0 = first cycle a request is high in IDLE. pmem_resp is high in cycles LATENCY..LATENCY+3. The earliest next acceptance is cycle LATENCY+5.
- Read: pmem_rdata is registered, showing beat k in the same cycle as the k-th resp. Outside BURST, pmem_rdata holds its last value.
- Write: on each clk edge where pmem_resp=1, pmem_wdata is written into beat k of the latched line. The master advances its beat on seeing resp, so beat k+1 is sampled next cycle.
- Read-after-write to the same line returns the new data on the next burst.
- Reset mid-burst: the burst is abandoned immediately. A partially written line keeps the beats already written.

Optional Feature:
- Macro: BURST_MEM_PROTOCOL_CHECK_EN.
- Defined: proto_err sets, and stays set until rst, on any of:
  - pmem_read and pmem_write both high in any cycle;
  - pmem_address changing while in WAIT or BURST;
  - the request dropping during BURST before beat 3.
  Each violation also triggers a simulation $error via an assertion.
- Undefined: proto_err is tied 0 and no checking logic is built.

Decomposition:
- rv32i_types additions:
  - enum pmem_resp_state_t {IDLE, WAIT, BURST, DONE}
  - constants BURST_BEATS=4, LINE_OFFSET_BITS=5, BEAT_WIDTH=64
- One sub-module: burst_mem_bank. It is a single 64-bit-wide array of 2**LINE_IDX_W entries with a synchronous write port and a registered read port, instantiated 4 times (one per beat).
- The responder owns the FSM, the counters, and beat muxing.

Test Plan:
- Write line 0x0000_0040 (index 2), beats 0x1111…,0x2222…,0x3333…,0x4444…, LATENCY=6 -> resp in cycles 6..9, then DONE. A read of 0x0000_0040 returns the same 4 beats in order in cycles 6..9.
- Read with LATENCY=1 -> resp in cycles 1..4. Next request accepted at cycle 6.
- Alias: write to 0x0000_2040 with LINE_IDX_W=8 -> a read of 0x0000_0040 returns that data.
- Abort: read asserted, dropped at cycle 3 of WAIT -> no resp ever. The next write burst starts its own LATENCY count.
- Async rst pulse at beat 2 of a write -> pmem_resp=0 the same cycle. A later read shows beats 0,1 new and beats 2,3 old.
- With BURST_MEM_PROTOCOL_CHECK_EN: read and write both high at cycle 0 -> proto_err=1 from the next edge until rst. Without the macro, proto_err stays 0.

Source files
------------

// File: rtl/burst_mem_responder_pkg.sv
// Shared types and constants for the burst memory responder and its storage banks.
package burst_mem_responder_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} pmem_resp_state_t;

  localparam int BURST_BEATS      = 4;
  localparam int LINE_OFFSET_BITS = 5;
  localparam int BEAT_WIDTH       = 64;

endpackage

// File: rtl/burst_mem_bank.sv
// One beat-wide slice of line storage: synchronous write, registered read.
module burst_mem_bank
  import burst_mem_responder_pkg::*;
#(
  parameter int IDX_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [BEAT_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [IDX_W-1:0]      raddr,
  output logic [BEAT_WIDTH-1:0] rdata
);

  logic [BEAT_WIDTH-1:0] mem [2**IDX_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register only updates when asked, so the last read beat is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/burst_mem_responder.sv
// 4-beat burst physical-memory endpoint with programmable first-beat latency.
// Optional BURST_MEM_PROTOCOL_CHECK_EN builds a sticky protocol-violation detector.
module burst_mem_responder
  import burst_mem_responder_pkg::*;
#(
  parameter int LINE_IDX_W = 8,
  parameter int LATENCY    = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pmem_read,
  input  logic                  pmem_write,
  input  logic [31:0]           pmem_address,
  input  logic [BEAT_WIDTH-1:0] pmem_wdata,
  output logic                  pmem_resp,
  output logic [BEAT_WIDTH-1:0] pmem_rdata,
  output logic                  proto_err
);

  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  pmem_resp_state_t      state, state_d;
  logic [7:0]            cnt, cnt_d;
  logic [1:0]            beat, beat_d;
  logic [LINE_IDX_W-1:0] idx, idx_d;
  logic                  op_wr, op_wr_d;
  logic [1:0]            rsel;
  logic                  req;
  logic [LINE_IDX_W-1:0] addr_idx;
  logic [BURST_BEATS-1:0] bank_re, bank_we;
  logic [BEAT_WIDTH-1:0] bank_rdata [BURST_BEATS];
  logic                  unused_addr;

  assign req         = pmem_read | pmem_write;
  assign addr_idx    = pmem_address[LINE_OFFSET_BITS +: LINE_IDX_W];
  assign unused_addr = ^pmem_address;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      beat  <= '0;
      idx   <= '0;
      op_wr <= 1'b0;
      rsel  <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      beat  <= beat_d;
      idx   <= idx_d;
      op_wr <= op_wr_d;
      if (|bank_re) rsel <= beat_d;
    end
  end

  // The counter holds the remaining WAIT cycles; LATENCY=1 skips WAIT entirely.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    beat_d  = beat;
    idx_d   = idx;
    op_wr_d = op_wr;
    case (state)
      IDLE: begin
        if (req) begin
          idx_d   = addr_idx;
          op_wr_d = ~pmem_read;
          cnt_d   = LAT_M1;
          beat_d  = '0;
          state_d = (LAT_M1 == 8'd0) ? BURST : WAIT;
        end
      end
      WAIT: begin
        if (!req) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt - 8'd1;
          if (cnt == 8'd1) state_d = BURST;
        end
      end
      BURST: begin
        beat_d = beat + 2'd1;
        if (beat == 2'd3) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign pmem_resp  = (state == BURST);
  assign pmem_rdata = bank_rdata[rsel];

  // Reads are issued one cycle ahead so each beat lands in its resp cycle.
  for (genvar k = 0; k < BURST_BEATS; k++) begin : g_bank
    assign bank_re[k] = (state_d == BURST) && !op_wr_d && (beat_d == 2'(k));
    assign bank_we[k] = (state == BURST) && op_wr && (beat == 2'(k));

    burst_mem_bank #(.IDX_W(LINE_IDX_W)) u_bank (
      .clk   (clk),
      .rst   (rst),
      .we    (bank_we[k]),
      .waddr (idx),
      .wdata (pmem_wdata),
      .re    (bank_re[k]),
      .raddr (idx_d),
      .rdata (bank_rdata[k])
    );
  end

`ifdef BURST_MEM_PROTOCOL_CHECK_EN
  logic [31-LINE_OFFSET_BITS:0] addr_q;
  logic both_hi, addr_moved, early_drop;

  assign both_hi    = pmem_read & pmem_write;
  assign addr_moved = req && (state == WAIT || state == BURST) &&
                      (pmem_address[31:LINE_OFFSET_BITS] != addr_q);
  assign early_drop = (state == BURST) && !req && (beat != 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      proto_err <= 1'b0;
      addr_q    <= '0;
    end else begin
      if (state == IDLE && req) addr_q <= pmem_address[31:LINE_OFFSET_BITS];
      if (both_hi || addr_moved || early_drop) proto_err <= 1'b1;
    end
  end

  a_no_both:    assert property (@(posedge clk) disable iff (rst) !both_hi)
    else $error("pmem_read and pmem_write both high");
  a_addr_held:  assert property (@(posedge clk) disable iff (rst) !addr_moved)
    else $error("pmem_address changed during an accepted request");
  a_no_drop:    assert property (@(posedge clk) disable iff (rst) !early_drop)
    else $error("request dropped before the last beat");
`else
  assign proto_err = 1'b0;
`endif

endmodule
